// File: rtl/tx_dump.sv
// tx_dump: on a rising edge of start_Tx, reads DUMP_WORDS bytes from a
// synchronous DRAM starting at address 0 and sends each one out as an
// 8N1 UART frame (LSB first, idle high). busy covers the whole dump and
// done flags its completion until the next accepted start edge or reset.
module tx_dump #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DUMP_WORDS   = 256,
    parameter int ADDR_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_Tx,
    input  logic [7:0]        dram_data,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Timer needs at least one bit even when a serial bit is a single clock.
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DUMP_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              start_q;
    logic [TW-1:0]     timer_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [ADDR_W-1:0] addr_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic              start_edge;
    logic              timer_wrap;

    // start_q resets high so a level already present at reset release is
    // never mistaken for a fresh request.
    assign start_edge = start_Tx & ~start_q;
    assign timer_wrap = (timer_q == TIMER_LAST);

    assign dram_addr = addr_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Previous-cycle copy of start_Tx for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_Tx;
        end
    end

    // Dump sequencer: address generation, bit timing and registered line drive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            addr_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Edges arriving in any other state are simply dropped.
                    if (start_edge) begin
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    // Address has been presented; RAM answers next cycle.
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    shift_q <= dram_data;
                    tx_q    <= 1'b0;
                    timer_q <= '0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (timer_wrap) begin
                        timer_q   <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer_wrap) begin
                        timer_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (timer_wrap) begin
                        timer_q <= '0;
                        if (addr_q == ADDR_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= S_READ;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_dump.sv
// Directed bench for tx_dump: a two-byte instance and a one-byte instance,
// each with CLKS_PER_BIT=4 and a small synchronous RAM model. Expected
// frames are written out by hand from the byte values.
module tb_tx_dump;

    logic        clk;
    logic        reset;
    logic        start2, start1;
    logic [7:0]  data2, data1;
    logic [15:0] addr2, addr1;
    logic        tx2, tx1, busy2, busy1, done2, done1;

    int checks = 0;
    int errors = 0;

    // Hand-derived 8N1 frames: 0xA5 then 0x3C (two-byte dut), 0xFF (one-byte dut).
    bit exp2 [20] = '{0,1,0,1,0,0,1,0,1,1, 0,0,0,1,1,1,1,0,0,1};
    bit exp1 [10] = '{0,1,1,1,1,1,1,1,1,1};

    logic [7:0] mem2 [2];

    tx_dump #(.CLKS_PER_BIT(4), .DUMP_WORDS(2), .ADDR_W(16)) u_dut2 (
        .clock(clk), .reset(reset), .start_Tx(start2), .dram_data(data2),
        .dram_addr(addr2), .tx(tx2), .busy(busy2), .done(done2)
    );

    tx_dump #(.CLKS_PER_BIT(4), .DUMP_WORDS(1), .ADDR_W(16)) u_dut1 (
        .clock(clk), .reset(reset), .start_Tx(start1), .dram_data(data1),
        .dram_addr(addr1), .tx(tx1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM models: data valid one clock after the address.
    always @(posedge clk) begin
        data2 <= mem2[addr2[0]];
        data1 <= (addr1 == 16'd0) ? 8'hFF : 8'h00;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 2) start2 = v;
        else            start1 = v;
    endtask

    // Raise start, then check every cycle from the detection edge to done.
    task automatic run_dump(input int which, input bit hold, input bit mid_pulse);
        int nb, b, o;
        logic etx;
        logic otx, obusy, odone;
        logic [15:0] oaddr;
        nb = (which == 2) ? 2 : 1;
        @(posedge clk); #1;
        set_start(which, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(which, 1'b0);
        for (int k = 0; k <= nb * 42; k++) begin
            @(negedge clk);
            otx   = (which == 2) ? tx2   : tx1;
            obusy = (which == 2) ? busy2 : busy1;
            odone = (which == 2) ? done2 : done1;
            oaddr = (which == 2) ? addr2 : addr1;
            b = k / 42;
            o = k % 42;
            if (k == nb * 42) begin
                check_val("end_tx",   {31'd0, otx},   32'd1);
                check_val("end_busy", {31'd0, obusy}, 32'd0);
                check_val("end_done", {31'd0, odone}, 32'd1);
                check_val("end_addr", {16'd0, oaddr}, nb - 1);
            end else begin
                if (o < 2)          etx = 1'b1;
                else if (which == 2) etx = exp2[b * 10 + (o - 2) / 4];
                else                etx = exp1[(o - 2) / 4];
                check_val("tx",   {31'd0, otx},   {31'd0, etx});
                check_val("busy", {31'd0, obusy}, 32'd1);
                check_val("done", {31'd0, odone}, 32'd0);
                check_val("addr", {16'd0, oaddr}, b);
            end
            if (mid_pulse && k == 20) set_start(which, 1'b1);
            if (mid_pulse && k == 23) set_start(which, 1'b0);
        end
        $display("dump dut%0d hold=%0d mid_pulse=%0d checked %0d cycles", which, hold, mid_pulse, nb * 42 + 1);
    endtask

    initial begin
        mem2[0] = 8'hA5;
        mem2[1] = 8'h3C;
        reset  = 1'b1;
        start2 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx",   {31'd0, tx2},   32'd1);
        check_val("rst_busy", {31'd0, busy2}, 32'd0);
        check_val("rst_done", {31'd0, done2}, 32'd0);
        check_val("rst_addr", {16'd0, addr2}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("idle_tx",   {31'd0, tx2},   32'd1);
        check_val("idle_busy", {31'd0, busy2}, 32'd0);
        $display("reset state checked");

        // Basic two-byte dump.
        run_dump(2, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check_val("after_done", {31'd0, done2}, 32'd1);
        check_val("after_tx",   {31'd0, tx2},   32'd1);

        // Restart from DONE with an extra start pulse mid-byte.
        run_dump(2, 1'b0, 1'b1);
        repeat (5) @(negedge clk);

        // start_Tx held high: exactly one dump, no retrigger.
        run_dump(2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(negedge clk);
            check_val("hold_done", {31'd0, done2}, 32'd1);
            check_val("hold_busy", {31'd0, busy2}, 32'd0);
            check_val("hold_tx",   {31'd0, tx2},   32'd1);
        end
        $display("held start produced a single dump");
        set_start(2, 1'b0);
        repeat (3) @(negedge clk);

        // Reset asserted mid-frame during data bit 3 of 0xA5 (line low there).
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int k = 0; k <= 19; k++) @(negedge clk);
        check_val("pre_rst_tx", {31'd0, tx2}, 32'd0);
        start2 = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_val("arst_tx",   {31'd0, tx2},   32'd1);
        check_val("arst_busy", {31'd0, busy2}, 32'd0);
        check_val("arst_done", {31'd0, done2}, 32'd0);
        check_val("arst_addr", {16'd0, addr2}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            repeat (10) @(negedge clk);
            check_val("post_rst_busy", {31'd0, busy2}, 32'd0);
            check_val("post_rst_tx",   {31'd0, tx2},   32'd1);
        end
        $display("async reset mid-frame checked");
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        run_dump(2, 1'b0, 1'b0);

        // Single-byte instance.
        run_dump(1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check_val("one_done", {31'd0, done1}, 32'd1);
        check_val("one_addr", {16'd0, addr1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
